mem_arbiter: RTL

//  Shares the single-port 16-bit instruction/data RAM between two requesters:

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port negedge-sampling RAM.
// Port A fetches, port B loads/stores; one access in flight, three-state req/ack FSM.
module mem_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int FIXED_PRI = 0
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_a_req,
  input  logic [ADDR_W-1:0] I_a_addr,
  output logic              O_a_ack,
  output logic [DATA_W-1:0] O_a_data,
  input  logic              I_b_req,
  input  logic              I_b_we,
  input  logic [ADDR_W-1:0] I_b_addr,
  input  logic [DATA_W-1:0] I_b_wdata,
  output logic              O_b_ack,
  output logic [DATA_W-1:0] O_b_data,
  output logic              O_ram_we,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [DATA_W-1:0] O_ram_data,
  input  logic [DATA_W-1:0] I_ram_data,
  output logic              O_busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic                last_b, last_b_nxt;
  logic                grant_b;
  logic                a_ack_nxt, b_ack_nxt, ram_we_nxt, busy_nxt;
  logic [DATA_W-1:0]   a_data_nxt, b_data_nxt, ram_data_nxt;
  logic [ADDR_W-1:0]   ram_addr_nxt;

  // last_b doubles as "current grant" once an access has started.
  always_comb begin
    state_nxt    = state;
    last_b_nxt   = last_b;
    grant_b      = 1'b0;
    a_ack_nxt    = O_a_ack;
    b_ack_nxt    = O_b_ack;
    a_data_nxt   = O_a_data;
    b_data_nxt   = O_b_data;
    ram_we_nxt   = O_ram_we;
    ram_addr_nxt = O_ram_addr;
    ram_data_nxt = O_ram_data;
    case (state)
      IDLE: begin
        if (I_a_req || I_b_req) begin
          if (I_a_req && I_b_req)
            grant_b = (FIXED_PRI != 0) ? 1'b1 : ~last_b;
          else
            grant_b = I_b_req;
          last_b_nxt   = grant_b;
          ram_we_nxt   = grant_b & I_b_we;
          ram_addr_nxt = grant_b ? I_b_addr : I_a_addr;
          ram_data_nxt = (grant_b && I_b_we) ? I_b_wdata : '0;
          state_nxt    = ACCESS;
        end
      end
      ACCESS: begin
        // O_ram_we is still high here only for a store, whose reply is zero.
        if (last_b) begin
          b_ack_nxt  = 1'b1;
          b_data_nxt = O_ram_we ? '0 : I_ram_data;
        end else begin
          a_ack_nxt  = 1'b1;
          a_data_nxt = I_ram_data;
        end
        ram_we_nxt = 1'b0;
        state_nxt  = RESP;
      end
      RESP: begin
        a_ack_nxt = 1'b0;
        b_ack_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      O_a_ack    <= 1'b0;
      O_b_ack    <= 1'b0;
      O_a_data   <= '0;
      O_b_data   <= '0;
      O_ram_we   <= 1'b0;
      O_ram_addr <= '0;
      O_ram_data <= '0;
      O_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_b     <= last_b_nxt;
      O_a_ack    <= a_ack_nxt;
      O_b_ack    <= b_ack_nxt;
      O_a_data   <= a_data_nxt;
      O_b_data   <= b_data_nxt;
      O_ram_we   <= ram_we_nxt;
      O_ram_addr <= ram_addr_nxt;
      O_ram_data <= ram_data_nxt;
      O_busy     <= busy_nxt;
    end
  end

endmodule
